// File: rtl/conv1d_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_stream
// Purpose  : Streaming 1D convolution (cross-correlation) engine with a
//            runtime-loaded kernel, symmetric zero padding, window stride,
//            ready/valid streams and a job-completion pulse.
//            out[w] = sum_k coef[k] * p[w*S + k], p = pad zeros, features,
//            pad zeros. Unsigned, full-precision arithmetic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a job (sampled in IDLE only)
//   cfg_len_i      feature sample count        (latched on start)
//   cfg_pad_i      zeros before and after data (latched on start)
//   cfg_stride_i   window step, 0 means 1      (latched on start)
//   coef_valid_i / coef_ready_o / coef_data_i   coefficient stream
//   in_valid_i   / in_ready_o   / in_data_i     feature stream
//   out_valid_o  / out_ready_i  / out_data_o    result stream
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse at job end
// ============================================================================
module conv1d_stream #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 3,
  localparam int OUT_W = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        cfg_len_i,
  input  logic [3:0]        cfg_pad_i,
  input  logic [3:0]        cfg_stride_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CC_W = $clog2(TAPS);
  localparam int PC_W = $clog2(TAPS + 1);
  localparam logic [CC_W-1:0] LAST_COEF = CC_W'(TAPS - 1);
  localparam logic [PC_W-1:0] TAPS_PC   = PC_W'(TAPS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_COEF = 3'd1,
    ST_PRE_PAD   = 3'd2,
    ST_STREAM    = 3'd3,
    ST_POST_PAD  = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Job configuration latched at start
  logic [7:0] len_q, len_d;
  logic [3:0] pad_q, pad_d;
  logic [3:0] stride_q, stride_d;

  // Shifts done in the current PRE_PAD / STREAM / POST_PAD phase
  logic [7:0] cnt_q, cnt_d;
  logic [CC_W-1:0] coef_idx_q, coef_idx_d;
  // Position counter; it only matters until the window is first full,
  // so it saturates at TAPS instead of counting the whole sequence.
  logic [PC_W-1:0] pos_q, pos_d;
  // Windows seen since the last eligible one, modulo stride
  logic [3:0] sph_q, sph_d;

  logic [COEF_W-1:0] coef_q [TAPS];
  logic [COEF_W-1:0] coef_d [TAPS];
  logic [DATA_W-1:0] win_q  [TAPS];
  logic [DATA_W-1:0] win_d  [TAPS];

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  // Shared combinational terms
  logic              out_free;
  logic              src_avail;
  logic              shift_en;
  logic [DATA_W-1:0] shift_val;
  logic [DATA_W-1:0] win_shift [TAPS];
  logic [OUT_W-1:0]  sum;
  logic [PC_W-1:0]   pos_inc;
  logic              win_full;
  logic              eligible;
  logic              stride_last;
  logic              last_pad;
  logic              last_len;
  logic              phase_last;

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // --------------------------------------------------------------------------
  // Shift control and window arithmetic
  // --------------------------------------------------------------------------
  always_comb begin
    out_free  = !out_valid_q || out_ready_i;
    src_avail = 1'b0;
    case (state_q)
      ST_PRE_PAD, ST_POST_PAD: src_avail = 1'b1;
      ST_STREAM:               src_avail = in_valid_i;
      default:                 src_avail = 1'b0;
    endcase
    shift_en  = src_avail && out_free;
    shift_val = (state_q == ST_STREAM) ? in_data_i : '0;

    // Oldest element at index 0, newest at TAPS-1, so win[k] = p[w+k]
    for (int k = 0; k < TAPS - 1; k++) begin
      win_shift[k] = win_q[k+1];
    end
    win_shift[TAPS-1] = shift_val;

    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + OUT_W'(coef_q[k]) * OUT_W'(win_shift[k]);
    end

    pos_inc     = (pos_q == TAPS_PC) ? pos_q : pos_q + PC_W'(1);
    win_full    = (pos_inc == TAPS_PC);
    eligible    = win_full && (sph_q == 4'd0);
    stride_last = (sph_q == stride_q - 4'd1);

    // PRE_PAD/POST_PAD are entered only with pad>0, STREAM only with len>0
    last_pad   = (cnt_q == {4'b0000, pad_q} - 8'd1);
    last_len   = (cnt_q == len_q - 8'd1);
    phase_last = (state_q == ST_STREAM) ? last_len : last_pad;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake / status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    coef_ready_o = 1'b0;
    in_ready_o   = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOAD_COEF;
      end
      ST_LOAD_COEF: begin
        coef_ready_o = 1'b1;
        if (coef_valid_i && (coef_idx_q == LAST_COEF)) begin
          if (pad_q != 4'd0)      state_d = ST_PRE_PAD;
          else if (len_q != 8'd0) state_d = ST_STREAM;
          else                    state_d = ST_FINISH;
        end
      end
      ST_PRE_PAD: begin
        if (shift_en && last_pad) begin
          state_d = (len_q != 8'd0) ? ST_STREAM : ST_POST_PAD;
        end
      end
      ST_STREAM: begin
        in_ready_o = out_free;
        if (shift_en && last_len) begin
          state_d = (pad_q != 4'd0) ? ST_POST_PAD : ST_FINISH;
        end
      end
      ST_POST_PAD: begin
        if (shift_en && last_pad) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        // Leave only once the last result has drained or is taken now
        if (out_free) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    len_d       = len_q;
    pad_d       = pad_q;
    stride_d    = stride_q;
    cnt_d       = cnt_q;
    coef_idx_d  = coef_idx_q;
    pos_d       = pos_q;
    sph_d       = sph_q;
    coef_d      = coef_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if ((state_q == ST_IDLE) && start_i) begin
      len_d      = cfg_len_i;
      pad_d      = cfg_pad_i;
      stride_d   = (cfg_stride_i == 4'd0) ? 4'd1 : cfg_stride_i;
      cnt_d      = '0;
      coef_idx_d = '0;
      pos_d      = '0;
      sph_d      = '0;
      for (int k = 0; k < TAPS; k++) begin
        win_d[k] = '0;
      end
    end

    if ((state_q == ST_LOAD_COEF) && coef_valid_i) begin
      coef_d[coef_idx_q] = coef_data_i;
      coef_idx_d = (coef_idx_q == LAST_COEF) ? '0 : coef_idx_q + CC_W'(1);
    end

    if (shift_en) begin
      win_d = win_shift;
      pos_d = pos_inc;
      cnt_d = phase_last ? 8'd0 : cnt_q + 8'd1;
      if (win_full) begin
        sph_d = stride_last ? 4'd0 : sph_q + 4'd1;
      end
    end

    // A fresh result takes priority over retiring the one being consumed
    if (shift_en && eligible) begin
      out_valid_d = 1'b1;
      out_data_d  = sum;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q       <= '0;
      pad_q       <= '0;
      stride_q    <= 4'd1;
      cnt_q       <= '0;
      coef_idx_q  <= '0;
      pos_q       <= '0;
      sph_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= '0;
        win_q[k]  <= '0;
      end
    end else begin
      len_q       <= len_d;
      pad_q       <= pad_d;
      stride_q    <= stride_d;
      cnt_q       <= cnt_d;
      coef_idx_q  <= coef_idx_d;
      pos_q       <= pos_d;
      sph_q       <= sph_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      coef_q      <= coef_d;
      win_q       <= win_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_stream
// Purpose  : Directed self-checking bench for conv1d_stream (TAPS=3, 4-bit
//            data and coefficients) with hand-computed expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv1d_stream;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int TAPS   = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [7:0]        cfg_len_i;
  logic [3:0]        cfg_pad_i;
  logic [3:0]        cfg_stride_i;
  logic              coef_valid_i;
  logic              coef_ready_o;
  logic [COEF_W-1:0] coef_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [9:0]        out_data_o;
  logic              busy_o;
  logic              done_o;

  conv1d_stream #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .cfg_len_i   (cfg_len_i),
    .cfg_pad_i   (cfg_pad_i),
    .cfg_stride_i(cfg_stride_i),
    .coef_valid_i(coef_valid_i),
    .coef_ready_o(coef_ready_o),
    .coef_data_i (coef_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int coefs [TAPS];
  int feats [16];
  int expv  [16];
  int n_exp;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job: loads coefs[], streams feats[0..len-1], compares every
  // consumed result against expv[0..n_exp-1]. Inputs change on the falling
  // edge; outputs are sampled 1 time unit later, well before the rising edge.
  task automatic run_job(input string name, input int len, input int pad,
                         input int stride, input int stall, input bit spurious);
    int  ci, fi, oi, nv, cyc, stall_left, done_cnt;
    bit  stall_used;
    ci = 0; fi = 0; oi = 0; nv = 0; cyc = 0; stall_left = 0; done_cnt = 0;
    stall_used = 1'b0;
    @(negedge clk_i);
    start_i      = 1'b1;
    cfg_len_i    = 8'(len);
    cfg_pad_i    = 4'(pad);
    cfg_stride_i = 4'(stride);
    @(negedge clk_i);
    start_i = 1'b0;
    chk($sformatf("%s.busy_rise", name), busy_o, 1);
    while (done_cnt == 0 && cyc < 300) begin
      if (spurious && cyc == 8) begin
        start_i      = 1'b1;
        cfg_len_i    = 8'd1;
        cfg_pad_i    = 4'd0;
        cfg_stride_i = 4'd3;
      end else begin
        start_i = 1'b0;
      end
      coef_valid_i = (ci < TAPS);
      coef_data_i  = '0;
      if (ci < TAPS) coef_data_i = COEF_W'(coefs[ci]);
      in_valid_i = (fi < len);
      in_data_i  = '0;
      if (fi < len) in_data_i = DATA_W'(feats[fi]);
      if (stall > 0 && !stall_used && out_valid_o) begin
        stall_left = stall;
        stall_used = 1'b1;
      end
      out_ready_i = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk($sformatf("%s.stall_data", name), out_data_o, expv[0]);
        chk($sformatf("%s.stall_in_ready", name), in_ready_o, 0);
        stall_left--;
      end
      if (coef_valid_i && coef_ready_o) ci++;
      if (in_valid_i && in_ready_o) fi++;
      if (out_valid_o) nv++;
      if (out_valid_o && out_ready_i) begin
        if (oi < n_exp) chk($sformatf("%s.out%0d", name, oi), out_data_o, expv[oi]);
        oi++;
      end
      if (done_o) done_cnt++;
      cyc++;
      @(negedge clk_i);
    end
    start_i      = 1'b0;
    coef_valid_i = 1'b0;
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b1;
    chk($sformatf("%s.done_seen", name), done_cnt, 1);
    chk($sformatf("%s.n_out", name), oi, n_exp);
    chk($sformatf("%s.coef_cnt", name), ci, TAPS);
    chk($sformatf("%s.in_cnt", name), fi, len);
    if (n_exp == 0) chk($sformatf("%s.valid_cycles", name), nv, 0);
    #1;
    chk($sformatf("%s.done_width", name), done_o, 0);
    chk($sformatf("%s.busy_fall", name), busy_o, 0);
  endtask

  task automatic set_base_data();
    coefs[0] = 1; coefs[1] = 2; coefs[2] = 3;
    feats[0] = 3; feats[1] = 2; feats[2] = 1;
  endtask

  task automatic set_exp_p2s1();
    expv[0] = 9; expv[1] = 12; expv[2] = 10; expv[3] = 4; expv[4] = 1;
    n_exp = 5;
  endtask

  initial begin
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    cfg_len_i    = '0;
    cfg_pad_i    = '0;
    cfg_stride_i = '0;
    coef_valid_i = 1'b0;
    coef_data_i  = '0;
    in_valid_i   = 1'b0;
    in_data_i    = '0;
    out_ready_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst.out_valid", out_valid_o, 0);
    chk("rst.out_data", out_data_o, 0);
    chk("rst.in_ready", in_ready_o, 0);
    chk("rst.coef_ready", coef_ready_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);

    set_base_data();
    expv[0] = 10; n_exp = 1;
    run_job("p0s1", 3, 0, 1, 0, 1'b0);

    set_exp_p2s1();
    run_job("p2s1", 3, 2, 1, 0, 1'b0);

    expv[0] = 9; expv[1] = 10; expv[2] = 1; n_exp = 3;
    run_job("p2s2", 3, 2, 2, 0, 1'b0);

    set_exp_p2s1();
    run_job("p2s0", 3, 2, 0, 0, 1'b0);

    set_exp_p2s1();
    run_job("stall", 3, 2, 1, 5, 1'b0);

    n_exp = 0;
    run_job("short", 2, 0, 1, 0, 1'b0);

    // p = 0,1,2,3,4,5,0 ; windows 0 and 3
    for (int i = 0; i < 5; i++) feats[i] = i + 1;
    expv[0] = 8; expv[1] = 26; n_exp = 2;
    run_job("p1s3", 5, 1, 3, 0, 1'b0);

    for (int i = 0; i < TAPS; i++) coefs[i] = 15;
    for (int i = 0; i < 4; i++) feats[i] = 15;
    expv[0] = 675; expv[1] = 675; n_exp = 2;
    run_job("max", 4, 0, 1, 0, 1'b0);

    // Abort mid-STREAM with an asynchronous reset
    set_base_data();
    @(negedge clk_i);
    start_i = 1'b1; cfg_len_i = 8'd3; cfg_pad_i = 4'd0; cfg_stride_i = 4'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      coef_valid_i = 1'b1;
      coef_data_i  = COEF_W'(coefs[i]);
      @(negedge clk_i);
    end
    coef_valid_i = 1'b0;
    in_valid_i   = 1'b1;
    in_data_i    = 4'd3;
    #1;
    chk("abort.pre_busy", busy_o, 1);
    chk("abort.pre_in_ready", in_ready_o, 1);
    @(negedge clk_i);
    in_data_i = 4'd2;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort.out_valid", out_valid_o, 0);
    chk("abort.out_data", out_data_o, 0);
    chk("abort.in_ready", in_ready_o, 0);
    chk("abort.coef_ready", coef_ready_o, 0);
    chk("abort.busy", busy_o, 0);
    chk("abort.done", done_o, 0);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fresh job after reset, with a start and cfg change while busy
    set_exp_p2s1();
    run_job("after_rst", 3, 2, 1, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
